// File: rtl/apb_mem_completer.sv
// APB completer memory with byte strobes, pseudo-random wait states,
// error signalling on bad addresses, and saturating read/write counters.

package apb_pkg;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic                      write;
    logic [APB_STRB_WIDTH-1:0] strb;
    logic [2:0]                prot;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
  } apb_resp_t;
endpackage

module apb_mem_completer
  import apb_pkg::*;
#(
  parameter int                        DEPTH     = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                        MAX_WAIT  = 7,
  parameter logic [15:0]               SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  apb_req_t    i_apb_s_req,
  input  logic        i_apb_s_psel,
  input  logic        i_apb_s_penable,
  output apb_resp_t   o_apb_s_resp,
  output logic        o_apb_s_pready,
  output logic        o_apb_s_pslverr,
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [APB_ADDR_WIDTH-1:0] WINDOW_BYTES = APB_ADDR_WIDTH'(DEPTH * 4);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [7:0]                waitCnt_q, waitCnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      write_q;
  logic [APB_STRB_WIDTH-1:0] strb_q;
  logic [APB_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [31:0]               rdCount_q, wrCount_q;

  logic                      setupSeen;
  logic [15:0]               lfsrNext;
  logic [7:0]                waitLoad;
  logic [APB_ADDR_WIDTH-1:0] offset;
  logic                      addrOk;
  logic [IDX_W-1:0]          wordIdx;
  logic                      pready;
  logic                      completeOk;
  logic                      unusedProt;

  // prot carries no meaning for this memory
  assign unusedProt = ^i_apb_s_req.prot;

  assign setupSeen = (state_q == ST_IDLE) && i_apb_s_psel && !i_apb_s_penable;

  // Galois LFSR, taps 16,14,13,11, shifting towards bit 0
  assign lfsrNext = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign waitLoad = 8'(32'(lfsr_q[7:0]) % 32'(MAX_WAIT + 1));

  // Window decode uses full-width subtraction; addresses below BASE_ADDR are rejected explicitly
  assign offset  = addr_q - BASE_ADDR;
  assign addrOk  = (addr_q >= BASE_ADDR) && (offset < WINDOW_BYTES) && (addr_q[1:0] == 2'b00);
  assign wordIdx = offset[2 +: IDX_W];

  assign pready     = (state_q == ST_WAIT) && (waitCnt_q == 8'd0) && i_apb_s_psel && i_apb_s_penable;
  assign completeOk = pready && addrOk;

  assign o_apb_s_pready    = pready;
  assign o_apb_s_pslverr   = pready && !addrOk;
  assign o_apb_s_resp.rdata = (completeOk && !write_q) ? mem_q[wordIdx] : '0;
  assign o_rd_count        = rdCount_q;
  assign o_wr_count        = wrCount_q;

  // Next-state logic: accept setup in IDLE, count down wait states, abort on dropped psel
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    lfsr_d    = lfsr_q;
    if (state_q == ST_IDLE) begin
      if (setupSeen) begin
        state_d   = ST_WAIT;
        waitCnt_d = waitLoad;
        lfsr_d    = lfsrNext;
      end
    end else begin
      if (!i_apb_s_psel) begin
        state_d = ST_IDLE;
      end else if (waitCnt_q != 8'd0) begin
        waitCnt_d = waitCnt_q - 8'd1;
      end else if (i_apb_s_penable) begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM, wait counter and LFSR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 8'd0;
      lfsr_q    <= SEED;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // Request fields are captured once at setup and held for the whole transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
    end else if (setupSeen) begin
      addr_q  <= i_apb_s_req.addr;
      wdata_q <= i_apb_s_req.wdata;
      write_q <= i_apb_s_req.write;
      strb_q  <= i_apb_s_req.strb;
    end
  end

  // Storage array: byte lanes written only on a successful write completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (completeOk && write_q) begin
      for (int b = 0; b < APB_STRB_WIDTH; b++) begin
        if (strb_q[b]) begin
          mem_q[wordIdx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Saturating counters of successful reads and writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdCount_q <= '0;
      wrCount_q <= '0;
    end else if (completeOk) begin
      if (write_q && (wrCount_q != 32'hFFFF_FFFF)) begin
        wrCount_q <= wrCount_q + 32'd1;
      end
      if (!write_q && (rdCount_q != 32'hFFFF_FFFF)) begin
        rdCount_q <= rdCount_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Self-checking bench: one zero-wait instance at base 0 driven from a fixed
// vector table, one 7-wait instance at base 0x80 driven randomly against a
// behavioural memory/LFSR model, plus abort and reset-in-flight sequences.

module tb_apb_mem_completer;
  import apb_pkg::*;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [31:0] BASE7 = 32'h80;

  logic        clk = 1'b0;
  logic        rst;
  apb_req_t    req;
  logic        psel0, psel7, penable;
  apb_resp_t   resp0, resp7;
  logic        pready0, pready7, err0, err7;
  logic [31:0] rdc0, wrc0, rdc7, wrc7;

  int vecCount  = 0;
  int missCount = 0;

  logic [15:0] lfsr7m;
  logic [31:0] refMem [32];
  int          expRd7, expWr7;

  always #5 clk = ~clk;

  apb_mem_completer #(.DEPTH(32), .BASE_ADDR(32'h0), .MAX_WAIT(0), .SEED(SEED)) dut0 (
    .clk(clk), .rst(rst), .i_apb_s_req(req), .i_apb_s_psel(psel0),
    .i_apb_s_penable(penable), .o_apb_s_resp(resp0), .o_apb_s_pready(pready0),
    .o_apb_s_pslverr(err0), .o_rd_count(rdc0), .o_wr_count(wrc0));

  apb_mem_completer #(.DEPTH(32), .BASE_ADDR(BASE7), .MAX_WAIT(7), .SEED(SEED)) dut7 (
    .clk(clk), .rst(rst), .i_apb_s_req(req), .i_apb_s_psel(psel7),
    .i_apb_s_penable(penable), .o_apb_s_resp(resp7), .o_apb_s_pready(pready7),
    .o_apb_s_pslverr(err7), .o_rd_count(rdc7), .o_wr_count(wrc7));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] expRdata;
    bit          expErr;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [15:0] lfsrStep(logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    psel0 = 1'b0; psel7 = 1'b0; penable = 1'b0;
  endtask

  // One full APB transfer to the chosen instance; returns sampled outputs and wait count
  task automatic applyStimulus(input bit useSeven, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic err, output int waits);
    logic rdy;
    @(negedge clk);
    psel0 = !useSeven; psel7 = useSeven; penable = 1'b0;
    req.addr = addr; req.wdata = wdata; req.write = wr; req.strb = strb;
    req.prot = 3'($urandom_range(0, 7));
    @(negedge clk);
    penable = 1'b1;
    req.addr = $urandom; req.wdata = $urandom; req.write = !wr; req.strb = 4'($urandom_range(0, 15));
    waits = 0;
    rdata = '0; err = 1'b0;
    forever begin
      #1;
      rdy = useSeven ? pready7 : pready0;
      if (rdy) begin
        rdata = useSeven ? resp7.rdata : resp0.rdata;
        err   = useSeven ? err7 : err0;
        break;
      end
      checkOutput("rdata_while_not_ready", useSeven ? resp7.rdata : resp0.rdata, 32'h0);
      if (waits >= 20) begin
        vecCount++; missCount++;
        $display("[TB] FAIL pready_timeout: got no pready after %0d cycles, expected at most 7", waits);
        psel0 = 1'b0; psel7 = 1'b0; penable = 1'b0;
        break;
      end
      waits++;
      @(negedge clk);
    end
  endtask

  // Transfer to the random-wait instance, checked against the reference model
  task automatic run7(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] rdata;
    logic        err;
    int          waits, expWait, idx;
    bit          ok;
    ok      = (addr >= BASE7) && (addr < BASE7 + 32'd128) && (addr[1:0] == 2'b00);
    idx     = int'((addr - BASE7) >> 2) & 31;
    expWait = int'(lfsr7m[7:0]) % 8;
    lfsr7m  = lfsrStep(lfsr7m);
    applyStimulus(1'b1, wr, addr, wdata, strb, rdata, err, waits);
    checkOutput("rand_waits", waits, expWait);
    checkOutput("rand_pslverr", {31'b0, err}, {31'b0, !ok});
    if (!ok) begin
      checkOutput("rand_err_rdata", rdata, 32'h0);
    end else if (wr) begin
      for (int b = 0; b < 4; b++) if (strb[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
      expWr7++;
    end else begin
      checkOutput("rand_rdata", rdata, refMem[idx]);
      expRd7++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          waits, expRd0, expWr0, guard;

    tbl[0]  = '{1'b1, 32'h04,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h04,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h08,       32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h08,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h08,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h80,       32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h02,       32'h12345678, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h04,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{1'b1, 32'h0C,       32'h55AA55AA, 4'h0, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 32'h0C,       32'h0,        4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 32'h7C,       32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h7C,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b0, 32'h7E,       32'h0,        4'h0, 32'h0,        1'b1};
    tbl[13] = '{1'b1, 32'hFFFFFFFC, 32'h77777777, 4'hF, 32'h0,        1'b1};

    rst = 1'b1; psel0 = 1'b0; psel7 = 1'b0; penable = 1'b0; req = '0;
    lfsr7m = SEED; expRd7 = 0; expWr7 = 0;
    for (int w = 0; w < 32; w++) refMem[w] = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    checkOutput("reset_pready", {30'b0, pready0, pready7}, 32'h0);
    checkOutput("reset_pslverr", {30'b0, err0, err7}, 32'h0);
    checkOutput("reset_rdata0", resp0.rdata, 32'h0);
    checkOutput("reset_counts", rdc0 | wrc0 | rdc7 | wrc7, 32'h0);
    rst = 1'b0;

    // Zero-wait instance driven from the vector table
    expRd0 = 0; expWr0 = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rdata, err, waits);
      checkOutput($sformatf("tbl%0d_waits", i), waits, 0);
      checkOutput($sformatf("tbl%0d_pslverr", i), {31'b0, err}, {31'b0, tbl[i].expErr});
      if (!tbl[i].wr || tbl[i].expErr) checkOutput($sformatf("tbl%0d_rdata", i), rdata, tbl[i].expRdata);
      if (!tbl[i].expErr) begin
        if (tbl[i].wr) expWr0++; else expRd0++;
      end
    end
    idleCycle();
    #1;
    checkOutput("tbl_wr_count", wrc0, expWr0);
    checkOutput("tbl_rd_count", rdc0, expRd0);

    // penable without a setup phase is ignored and does not consume an LFSR step
    @(negedge clk);
    psel7 = 1'b1; penable = 1'b1;
    #1 checkOutput("idle_penable_pready", {31'b0, pready7}, 32'h0);
    @(negedge clk);
    #1 checkOutput("idle_penable_pready2", {31'b0, pready7}, 32'h0);
    idleCycle();

    // Random traffic against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 511));
      else a = BASE7 + 32'($urandom_range(0, 31)) * 4;
      run7(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    idleCycle();
    #1;
    checkOutput("rand_wr_count", wrc7, expWr7);
    checkOutput("rand_rd_count", rdc7, expRd7);

    // Abort: drop psel while three wait states remain
    guard = 0;
    while ((int'(lfsr7m[7:0]) % 8) != 3 && guard < 200) begin
      run7(1'b0, BASE7, 32'h0, 4'h0);
      guard++;
    end
    checkOutput("abort_found_wait3", int'(lfsr7m[7:0]) % 8, 3);
    @(negedge clk);
    psel7 = 1'b1; penable = 1'b0;
    req.addr = BASE7 + 32'h4; req.wdata = 32'h0BADF00D; req.write = 1'b1; req.strb = 4'hF;
    lfsr7m = lfsrStep(lfsr7m);
    @(negedge clk);
    penable = 1'b1;
    #1 checkOutput("abort_pready_a", {31'b0, pready7}, 32'h0);
    @(negedge clk);
    #1 checkOutput("abort_pready_b", {31'b0, pready7}, 32'h0);
    psel7 = 1'b0; penable = 1'b0;
    #1 checkOutput("abort_pready_c", {31'b0, pready7}, 32'h0);
    run7(1'b0, BASE7 + 32'h4, 32'h0, 4'h0);
    run7(1'b1, BASE7 + 32'h10, 32'h600DCAFE, 4'hF);
    run7(1'b0, BASE7 + 32'h10, 32'h0, 4'h0);
    idleCycle();
    #1;
    checkOutput("abort_wr_count", wrc7, expWr7);

    // Reset while a write would complete: no commit, state back to reset values
    guard = 0;
    while ((int'(lfsr7m[7:0]) % 8) != 1 && guard < 200) begin
      run7(1'b0, BASE7, 32'h0, 4'h0);
      guard++;
    end
    checkOutput("reset_found_wait1", int'(lfsr7m[7:0]) % 8, 1);
    @(negedge clk);
    psel7 = 1'b1; penable = 1'b0;
    req.addr = BASE7 + 32'h8; req.wdata = 32'h12345678; req.write = 1'b1; req.strb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1 checkOutput("rstmid_pready_wait", {31'b0, pready7}, 32'h0);
    @(negedge clk);
    #1 checkOutput("rstmid_pready_due", {31'b0, pready7}, 32'h1);
    rst = 1'b1;
    #1 checkOutput("rstmid_pready_cleared", {31'b0, pready7}, 32'h0);
    @(negedge clk);
    checkOutput("rstmid_counts", rdc7 | wrc7, 32'h0);
    rst = 1'b0; psel7 = 1'b0; penable = 1'b0;
    lfsr7m = SEED; expRd7 = 0; expWr7 = 0;
    for (int w = 0; w < 32; w++) refMem[w] = '0;
    run7(1'b0, BASE7 + 32'h8, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) run7(1'b0, BASE7 + 32'(i) * 4, 32'h0, 4'h0);
    idleCycle();
    #1;
    checkOutput("post_reset_rd_count", rdc7, expRd7);
    checkOutput("post_reset_wr_count", wrc7, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
